// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 7/8 data bits, optional parity, 1/2 stop bits.
// Define UART_RX_OVERRUN_EN to enable the full/overrun handshake with rd_ack.
module uart_rx #(
  parameter int D = 7
) (
  input  logic       clk_r,
  input  logic       rst_r_n,
  input  logic       S1200,
  input  logic       S2400,
  input  logic       S4800,
  input  logic       S9600,
  input  logic [1:0] bd_rate,
  input  logic       d_num,
  input  logic [1:0] para,
  input  logic       s_num,
  input  logic       in_data,
  input  logic       rd_ack,
  output logic [D:0] out_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic       full,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, next_state;

  logic       rx_m, rx_s, rx_d;
  logic       tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic [D:0] data_sr;
  logic       d_num_l, par_en_l, par_odd_l, s_num_l;
  logic       par_err_i, frm_err_i;

  logic       start_edge, confirm, mid, last_data, last_stop, frame_done;
  logic       par_exp;

  // The line idles high, so the synchronizer resets high to avoid a phantom start edge.
  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= in_data;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_comb begin
    tick = 1'b0;
    case (bd_rate)
      2'd0: tick = S1200;
      2'd1: tick = S2400;
      2'd2: tick = S4800;
      default: tick = S9600;
    endcase
  end

  assign start_edge = (state == IDLE) && rx_d && !rx_s;
  assign confirm    = (state == START) && tick && (tick_cnt == 4'd7);
  assign mid        = tick && (tick_cnt == 4'd15);
  assign last_data  = (bit_cnt == (d_num_l ? 3'd7 : 3'd6));
  assign last_stop  = (stop_cnt == s_num_l);
  assign frame_done = (state == STOP) && mid && last_stop;
  assign par_exp    = (^data_sr) ^ par_odd_l;

  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (start_edge) next_state = START;
      START:  if (confirm) next_state = rx_s ? IDLE : DATA;
      DATA:   if (mid && last_data) next_state = par_en_l ? PARITY : STOP;
      PARITY: if (mid) next_state = STOP;
      STOP:   if (mid && last_stop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Sampling counters and the per-frame format/error state, all restarted at start confirm.
  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      data_sr   <= '0;
      d_num_l   <= 1'b0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      s_num_l   <= 1'b0;
      par_err_i <= 1'b0;
      frm_err_i <= 1'b0;
    end else begin
      if (start_edge) begin
        tick_cnt <= '0;
      end else if (confirm) begin
        tick_cnt  <= '0;
        bit_cnt   <= '0;
        stop_cnt  <= 1'b0;
        data_sr   <= '0;
        d_num_l   <= d_num;
        par_en_l  <= para[0] ^ para[1];
        par_odd_l <= para[0];
        s_num_l   <= s_num;
        par_err_i <= 1'b0;
        frm_err_i <= 1'b0;
      end else if (tick && (state != IDLE)) begin
        tick_cnt <= tick_cnt + 4'd1;
      end

      if (mid) begin
        case (state)
          DATA: begin
            data_sr[bit_cnt] <= rx_s;
            bit_cnt          <= bit_cnt + 3'd1;
          end
          PARITY: if (rx_s != par_exp) par_err_i <= 1'b1;
          STOP: begin
            if (!rx_s) frm_err_i <= 1'b1;
            stop_cnt <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      out_data   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= frame_done;
      if (frame_done) begin
        out_data   <= data_sr;
        parity_err <= par_err_i;
        frame_err  <= frm_err_i | !rx_s;
      end
    end
  end

`ifdef UART_RX_OVERRUN_EN
  // A strobe with an acknowledge in the same cycle counts as consumed in time, not an overrun.
  always_ff @(posedge clk_r or negedge rst_r_n) begin
    if (!rst_r_n) begin
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rx_valid) begin
        full <= 1'b1;
        if (full && !rd_ack) overrun <= 1'b1;
        else if (rd_ack)     overrun <= 1'b0;
      end else if (rd_ack) begin
        full    <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end
`else
  logic unused_rd_ack;
  assign unused_rd_ack = rd_ack;
  assign full          = 1'b0;
  assign overrun       = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART IP: the far end of the transmit block's line. It accepts a 7- or 8-bit frame with optional odd/even parity and 1 or 2 stop bits, using the same selector encodings as the transmitter (`bd_rate`, `d_num`, `para`, `s_num`). It samples at 16x oversampling on one system clock, checks parity and framing, and presents the received byte with a one-cycle valid strobe.

## Interface
- D, 7, MSB index of data bus (8-bit data)
- clk_r  in  1  system clock, all logic on posedge
- rst_r_n  in  1  asynchronous, active-low reset
- S1200, S2400, S4800, S9600  in  1 each  one-`clk_r` pulses at 16x the named baud rate, synchronous to `clk_r`
- bd_rate  in  2  tick select: 0=S1200, 1=S2400, 2=S4800, 3=S9600
- d_num  in  1  1 = 8 data bits, 0 = 7 data bits
- para  in  2  00 = none, 01 = odd, 10 = even, 11 = treated as none
- s_num  in  1  1 = 2 stop bits, 0 = 1 stop bit
- in_data  in  1  serial line, idle high, asynchronous to `clk_r`
- rd_ack  in  1  consumer has taken `out_data` (used only with `UART_RX_OVERRUN_EN`)
- out_data  out  D+1  received data, LSB = first bit on line; bit 7 = 0 in 7-bit mode
- rx_valid  out  1  one-cycle strobe: frame complete, outputs updated
- parity_err  out  1  parity mismatch on last frame
- frame_err  out  1  a stop bit sampled low on last frame
- busy  out  1  FSM not in IDLE
- full  out  1  unread data held (macro only)
- overrun  out  1  frame completed while `full` (macro only)

## Operation
- `in_data` passes through a 2-flop synchronizer to `rx_s`; its previous value is held in `rx_d`.
- `tick` = strobe selected by `bd_rate`. The 4-bit `tick_cnt` advances only on `tick`.
- `d_num`, `para`, `s_num` are latched at the start-bit confirm and are fixed for that frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `rx_d`=1 and `rx_s`=0 (falling edge) -> START, `tick_cnt`=0. A line that is already low never starts a frame.
- START: on the 8th tick (`tick_cnt`==7), if `rx_s`=0 -> DATA, `tick_cnt`=0, `bit_cnt`=0. If `rx_s`=1 it is a false start -> IDLE with no strobe.
- DATA: on every 16th tick (`tick_cnt`==15, the bit midpoint) shift `rx_s` in at index `bit_cnt`, LSB first. After bit 7 (8-bit) or bit 6 (7-bit) -> PARITY if `para` is 01/10, else -> STOP.
- PARITY: sample at midpoint. Expected bit: even = XOR of data bits; odd = its inverse. A mismatch sets the internal error. -> STOP.
- STOP: sample at each midpoint; any 0 sets the internal frame error. After the 1st stop (`s_num`=0) or 2nd stop (`s_num`=1): load `out_data`, `parity_err`, `frame_err`, pulse `rx_valid`, -> IDLE.
- Outputs hold until the next `rx_valid`. A frame error still produces `rx_valid`.
- Line low through stop (break): `frame_err`=1, then IDLE waits for a falling edge before it starts again.

## Timing
- Reset values: `out_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, `full`=0, `overrun`=0, FSM=IDLE, all counters 0.
- Input latency: 2 `clk_r` from the synchronizer.
- `rx_valid` is asserted in the `clk_r` cycle after the tick that samples the last stop bit midpoint: 8 + 16·(N−1) ticks after the start edge, where N = 1 + data + parity + stop bits.
- `rst_r_n` low mid-frame clears everything immediately. No strobe is issued for the aborted frame.
- A change on `bd_rate` or the frame selectors mid-frame affects only the tick source. The frame format stays latched.

## Configuration
- `UART_RX_OVERRUN_EN` defined:
  - `full` is set on `rx_valid` and cleared on `rd_ack`.
  - If `rx_valid` occurs while `full`=1 and `rd_ack`=0, then `overrun`=1. It stays set until `rd_ack`.
  - New data overwrites old data.
  - `rx_valid` and `rd_ack` in the same cycle: `full` stays 1 and `overrun` is not set.
- Not defined: `rd_ack` is ignored, and `full` and `overrun` are tied to 0.

## Test plan
- bd_rate=3, d_num=1, para=10, s_num=0, send 0xA5 with parity 0 -> `out_data`=0xA5, `parity_err`=0, `frame_err`=0, one `rx_valid`.
- d_num=0, para=01, s_num=1, send 0x35 (7 bits) with parity 1, two stops -> `out_data`=0x35, no errors. `rx_valid` 8+16·10 ticks after the start edge.
- para=10, send 0x01 with parity bit 0 -> `parity_err`=1, `out_data`=0x01.
- s_num=1, second stop driven 0 -> `frame_err`=1. Line held low afterward -> no new frame until a high-to-low edge.
- 4-tick low glitch on idle line -> returns to IDLE, no `rx_valid`, `busy` pulses only. Then `rst_r_n` low during DATA -> all outputs 0 immediately.
- Macro defined: two frames without `rd_ack` -> `full`=1, `overrun`=1, `out_data`=second byte. Then `rd_ack` -> both 0.
